// File: rtl/midi_note_receiver.sv
// midi_note_receiver
//   Receives a MIDI serial stream, decodes note-on / note-off messages for
//   one channel and drives a single-voice (last-note priority) output.
//
//   Pipeline: 2-flop synchronizer -> UART byte receiver -> message parser
//             -> voice output stage.  trig rises two clocks after the
//             stop-bit sample of the byte that completes a note-on.
//
// Parameters
//   CLK_HZ    system clock frequency in Hz
//   BAUD      MIDI bit rate
//   CHANNEL   MIDI channel (0-15) whose note messages are accepted
//
// Ports
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   midi_rx    asynchronous serial MIDI line, idle high
//   note       key number of the last accepted note-on (48 after reset)
//   velocity   velocity of the last accepted note-on
//   gate       high while the current note is held
//   trig       one-clock pulse per accepted note-on
//   frame_err  one-clock pulse per received byte with a low stop bit
module midi_note_receiver #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 31_250,
  parameter int CHANNEL = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       midi_rx,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic       trig,
  output logic       frame_err
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [3:0]       CH        = CHANNEL[3:0];

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
  typedef enum logic [1:0] {P_WAIT_STATUS, P_WAIT_KEY, P_WAIT_VEL} parse_state_e;

  // ---------------------------------------------------------------------
  // Synchronizer; rx_prev_q gives the previous synchronized level for
  // falling-edge detection. All three reset to the idle (high) level.
  // ---------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // NOTE: sequential state is always written with non-blocking assignments
  // so every flop samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= midi_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------------------------------------------------------------
  // UART receiver. cnt_q is the baud counter; the start bit is checked
  // half a bit after the falling edge, then each later sample is one full
  // bit after the previous, landing on bit midpoints.
  // ---------------------------------------------------------------------
  uart_state_e      uart_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             byte_valid_q;
  logic             frame_err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      uart_q       <= U_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (uart_q)
        U_IDLE: begin
          cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) uart_q <= U_START;
        end
        U_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // A line already back high was a glitch: drop it silently.
            uart_q    <= rx_sync_q ? U_IDLE : U_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        U_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};  // LSB arrives first
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) uart_q <= U_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        U_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q        <= '0;
            uart_q       <= U_IDLE;
            byte_valid_q <= rx_sync_q;
            frame_err_q  <= !rx_sync_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: uart_q <= U_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Message parser. Running status is valid exactly when the parser is
  // out of P_WAIT_STATUS; run_on_q records note-on (1) or note-off (0).
  // A completed message is handed on as a one-clock msg_valid_q event.
  // ---------------------------------------------------------------------
  parse_state_e parse_q;
  logic         run_on_q;
  logic [6:0]   key_q;
  logic         msg_valid_q;
  logic         msg_on_q;
  logic [6:0]   msg_key_q;
  logic [6:0]   msg_vel_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      parse_q     <= P_WAIT_STATUS;
      run_on_q    <= 1'b0;
      key_q       <= '0;
      msg_valid_q <= 1'b0;
      msg_on_q    <= 1'b0;
      msg_key_q   <= '0;
      msg_vel_q   <= '0;
    end else begin
      msg_valid_q <= 1'b0;
      if (byte_valid_q) begin
        if (shift_q[7:3] == 5'b11111) begin
          // Real-time byte: invisible to the message stream.
        end else if (shift_q[7:4] == 4'hF) begin
          parse_q <= P_WAIT_STATUS;
        end else if (shift_q[7]) begin
          // 0x8n / 0x9n on our channel start a message; anything else
          // kills running status so its data bytes are ignored.
          if (shift_q[7:5] == 3'b100 && shift_q[3:0] == CH) begin
            run_on_q <= shift_q[4];
            parse_q  <= P_WAIT_KEY;
          end else begin
            parse_q <= P_WAIT_STATUS;
          end
        end else begin
          case (parse_q)
            P_WAIT_KEY: begin
              key_q   <= shift_q[6:0];
              parse_q <= P_WAIT_VEL;
            end
            P_WAIT_VEL: begin
              msg_valid_q <= 1'b1;
              msg_on_q    <= run_on_q && (shift_q[6:0] != 7'd0);
              msg_key_q   <= key_q;
              msg_vel_q   <= shift_q[6:0];
              parse_q     <= P_WAIT_KEY;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Voice output stage: single voice, last-note priority.
  // ---------------------------------------------------------------------
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       gate_q, gate_d;
  logic       trig_q, trig_d;

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    note_d = note_q;
    vel_d  = vel_q;
    gate_d = gate_q;
    trig_d = 1'b0;
    if (msg_valid_q) begin
      if (msg_on_q) begin
        note_d = msg_key_q;
        vel_d  = msg_vel_q;
        gate_d = 1'b1;
        trig_d = 1'b1;
      end else if (msg_key_q == note_q) begin
        // Releasing an older, superseded key leaves the voice alone.
        gate_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      note_q <= 7'd48;
      vel_q  <= '0;
      gate_q <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      note_q <= note_d;
      vel_q  <= vel_d;
      gate_q <= gate_d;
      trig_q <= trig_d;
    end
  end

  assign note      = note_q;
  assign velocity  = vel_q;
  assign gate      = gate_q;
  assign trig      = trig_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_midi_note_receiver.sv
// Testbench for midi_note_receiver: table-driven message vectors, hand
// sequences for framing error, glitch, mid-frame reset and trig timing,
// then a randomized byte stream checked against a behavioural model.
module tb_midi_note_receiver;

  localparam int  TB_CLK_HZ = 500_000;
  localparam int  TB_BAUD   = 31_250;
  localparam int  DIV       = TB_CLK_HZ / TB_BAUD;  // 16 clocks per bit
  localparam time CLK_P     = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       midi_rx = 1'b1;
  logic [6:0] note, velocity;
  logic       gate, trig, frame_err;

  midi_note_receiver #(
    .CLK_HZ (TB_CLK_HZ),
    .BAUD   (TB_BAUD),
    .CHANNEL(0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .midi_rx  (midi_rx),
    .note     (note),
    .velocity (velocity),
    .gate     (gate),
    .trig     (trig),
    .frame_err(frame_err)
  );

  always #(CLK_P / 2) clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int  trig_cnt = 0, trig_wide = 0, ferr_cnt = 0, ferr_wide = 0;
  bit  trig_prev = 0, ferr_prev = 0;
  time last_trig_t = 0, last_start_t = 0;

  always @(negedge clk) begin
    if (trig) begin
      trig_cnt++;
      if (trig_prev) trig_wide++;
      else last_trig_t = $time;
    end
    if (frame_err) begin
      ferr_cnt++;
      if (ferr_prev) ferr_wide++;
    end
    trig_prev = trig;
    ferr_prev = frame_err;
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    midi_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One full frame followed by two idle bit times.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    midi_rx = 1'b0;
    last_start_t = $time;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    midi_rx = stop_bit;
    repeat (DIV) @(negedge clk);
    midi_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input int en, input int ev, input int eg);
    check({tag, " note"}, int'(note), en);
    check({tag, " velocity"}, int'(velocity), ev);
    check({tag, " gate"}, int'(gate), eg);
  endtask

  // Behavioural model: running status is the status byte's high nibble
  // (or -1), pending key is -1 while a key byte is awaited.
  int m_note, m_vel, m_gate, m_run, m_key, m_trigs;

  task automatic model_reset();
    m_note = 48; m_vel = 0; m_gate = 0; m_run = -1; m_key = -1;
  endtask

  task automatic model_byte(input int b);
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin
      m_run = -1;
      return;
    end
    if (b >= 'h80) begin
      if (((b >> 4) == 9 || (b >> 4) == 8) && (b % 16) == 0) m_run = b >> 4;
      else m_run = -1;
      m_key = -1;
      return;
    end
    if (m_run < 0) return;
    if (m_key < 0) begin
      m_key = b;
      return;
    end
    if (m_run == 9 && b != 0) begin
      m_note = m_key; m_vel = b; m_gate = 1; m_trigs++;
    end else if (m_key == m_note) begin
      m_gate = 0;
    end
    m_key = -1;
  endtask

  typedef struct {
    bit         rst;
    int         len;
    logic [79:0] bytes;  // right-aligned, first byte most significant
    int         note, vel, gate, trigs;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit rst, input int len, input logic [79:0] bytes,
                         input int n, input int v, input int g, input int t);
    vec_t x;
    x.rst = rst; x.len = len; x.bytes = bytes;
    x.note = n; x.vel = v; x.gate = g; x.trigs = t;
    vecs.push_back(x);
  endtask

  initial begin
    int t0, f0, lat;
    logic [7:0] b;

    // Reset state.
    do_reset();
    check_outputs("reset", 48, 0, 0);
    check("reset trig", int'(trig), 0);
    check("reset frame_err", int'(frame_err), 0);

    // Message vectors (rst, len, bytes, note, velocity, gate, trig pulses).
    add_vec(1, 3, 80'h903C64,               60, 100, 1, 1);
    add_vec(0, 2, 80'h407F,                 64, 127, 1, 1);
    add_vec(0, 2, 80'h4000,                 64, 127, 0, 0);
    add_vec(1, 9, 80'h903C64904050803C00,   64,  80, 1, 2);
    add_vec(0, 3, 80'h804000,               64,  80, 0, 0);
    add_vec(1, 4, 80'h90F83C64,             60, 100, 1, 1);
    add_vec(0, 3, 80'h913C64,               60, 100, 1, 0);
    add_vec(0, 3, 80'hF03C64,               60, 100, 1, 0);
    add_vec(0, 5, 80'h903E90417F,           65, 127, 1, 1);

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst) do_reset();
      t0 = trig_cnt;
      for (int i = 0; i < vecs[k].len; i++) begin
        b = vecs[k].bytes[8 * (vecs[k].len - 1 - i) +: 8];
        send_frame(b, 1'b1);
      end
      check_outputs($sformatf("vec%0d", k), vecs[k].note, vecs[k].vel, vecs[k].gate);
      check($sformatf("vec%0d trigs", k), trig_cnt - t0, vecs[k].trigs);
      // trig follows the stop-bit midpoint (9.5 bits) plus sync and 2 clks.
      if (k == 0) begin
        lat = int'((last_trig_t - last_start_t) / CLK_P);
        check("trig latency in window",
              int'(lat >= DIV * 19 / 2 + 2 && lat <= DIV * 19 / 2 + 7), 1);
      end
    end

    // Framing error: stop bit low -> one pulse, nothing else changes.
    f0 = ferr_cnt; t0 = trig_cnt;
    send_frame(8'h90, 1'b0);
    check("frame_err pulses", ferr_cnt - f0, 1);
    check_outputs("after frame_err", 65, 127, 1);
    check("frame_err no trig", trig_cnt - t0, 0);

    // 0.3-bit glitch on the idle line: no byte, no error.
    f0 = ferr_cnt; t0 = trig_cnt;
    @(negedge clk);
    midi_rx = 1'b0;
    repeat (DIV * 3 / 10) @(negedge clk);
    midi_rx = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    check("glitch frame_err", ferr_cnt - f0, 0);
    check("glitch trig", trig_cnt - t0, 0);
    check_outputs("after glitch", 65, 127, 1);
    // A full message right after the glitch still decodes.
    send_frame(8'h90, 1'b1); send_frame(8'h30, 1'b1); send_frame(8'h11, 1'b1);
    check_outputs("post-glitch msg", 48, 17, 1);

    // Reset after start bit + 4 data bits of 0x90 (all four are 0).
    @(negedge clk);
    midi_rx = 1'b0;
    repeat (5 * DIV) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    midi_rx = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs("mid-frame reset", 48, 0, 0);
    check("mid-frame reset trig", int'(trig), 0);
    t0 = trig_cnt;
    send_frame(8'h90, 1'b1); send_frame(8'h3C, 1'b1); send_frame(8'h64, 1'b1);
    check_outputs("post-reset msg", 60, 100, 1);
    check("post-reset trigs", trig_cnt - t0, 1);

    // Randomized stream against the model.
    do_reset();
    model_reset();
    m_trigs = 0;
    t0 = trig_cnt;
    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1: b = 8'h90;
        2:    b = 8'h80;
        3:    b = 8'($urandom_range('h81, 'hEF));
        4:    b = 8'($urandom_range('hF8, 'hFF));
        5:    b = 8'($urandom_range('hF0, 'hF7));
        default: begin
          case ($urandom_range(0, 4))
            0: b = 8'h3C;
            1: b = 8'h3E;
            2: b = 8'h40;
            3: b = 8'h00;
            default: b = 8'($urandom_range(0, 'h7F));
          endcase
        end
      endcase
      send_frame(b, 1'b1);
      model_byte(int'(b));
      check_outputs($sformatf("rand%0d byte %02h", n, b), m_note, m_vel, m_gate);
      check($sformatf("rand%0d trigs", n), trig_cnt - t0, m_trigs);
    end

    check("trig width violations", trig_wide, 0);
    check("frame_err width violations", ferr_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
